// File: rtl/ad9866_spi_master.sv
// AD9866 SPI register controller: init-table playback, queued host writes and
// optional 4-wire register readback (enabled by defining AD9866_READBACK_EN).
module ad9866_spi_master #(
    parameter int    ADDR_W     = 5,
    parameter int    DATA_W     = 8,
    parameter int    FRAME_W    = 3 + ADDR_W + DATA_W,
    parameter int    CLK_DIV    = 2,
    parameter int    INIT_DEPTH = 20,
    parameter string INIT_FILE  = "ad9866_init.hex",
    parameter int    FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [5:0]        cmd_addr,
    input  logic [31:0]       cmd_data,
    input  logic              cmd_rqst,
    output logic              cmd_ack,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              init_done,
    output logic              rffe_ad9866_sdio,
    input  logic              rffe_ad9866_sdo,
    output logic              rffe_ad9866_sclk,
    output logic              rffe_ad9866_sen_n
);
    localparam int ENT_W = 1 + ADDR_W + DATA_W;
    localparam int PTR_W = $clog2(INIT_DEPTH);
    localparam int FP_W  = $clog2(FIFO_DEPTH);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(FRAME_W);
    localparam bit BUILTIN = (INIT_FILE == "ad9866_init.hex");

    // ROM image of ad9866_init.hex ({enable, data}); unknown file names give an empty table.
    function automatic logic [DATA_W:0] init_entry(input int i);
        init_entry = '0;
        if (BUILTIN) begin
            case (i)
                4:  init_entry = {1'b1, DATA_W'(8'h36)};
                5:  init_entry = {1'b1, DATA_W'(8'h00)};
                6:  init_entry = {1'b1, DATA_W'(8'h1C)};
                7:  init_entry = {1'b1, DATA_W'(8'h00)};
                8:  init_entry = {1'b1, DATA_W'(8'h00)};
                9:  init_entry = {1'b1, DATA_W'(8'h08)};
                10: init_entry = {1'b1, DATA_W'(8'h20)};
                11: init_entry = {1'b1, DATA_W'(8'h80)};
                12: init_entry = {1'b1, DATA_W'(8'h40)};
                13: init_entry = {1'b1, DATA_W'(8'h0F)};
                14: init_entry = {1'b1, DATA_W'(8'h01)};
                15: init_entry = {1'b1, DATA_W'(8'h44)};
                18: init_entry = {1'b1, DATA_W'(8'h00)};
                default: init_entry = '0;
            endcase
        end
    endfunction

    typedef enum logic [2:0] {S_INIT, S_IDLE, S_LOAD, S_LO, S_HI, S_GAP} state_t;
    state_t state, nxt;

    logic [PTR_W-1:0] ptr;
    logic [DIV_W-1:0] div_cnt;
    logic [BIT_W-1:0] bit_cnt;
    logic             gap_cnt;
    logic [FRAME_W-1:0] tx;
    logic [ENT_W-1:0] fifo [FIFO_DEPTH];
    logic [FP_W-1:0]  wr_ptr, rd_ptr;
    logic [FP_W:0]    count;
    logic [DATA_W:0]  init_cur;
    logic [ENT_W-1:0] ld_ent, push_ent;
    logic hit, wr_op, rd_op, queue_op, full, accept, push, pop;
    logic ptr_last, div_end, bit_last, shift_end, init_step;

    assign init_cur = init_entry(int'(ptr));
    assign hit      = cmd_addr == 6'h3b;
    assign wr_op    = hit && cmd_data[31:24] == 8'h06;
`ifdef AD9866_READBACK_EN
    assign rd_op    = hit && cmd_data[31:24] == 8'h07;
`else
    assign rd_op    = 1'b0;
`endif
    assign queue_op = wr_op || rd_op;
    assign full     = count == (FP_W+1)'(FIFO_DEPTH);
    // cmd_ack high blocks the still-held request from being taken twice
    assign accept   = cmd_rqst && !cmd_ack && (!queue_op || !full);
    assign push     = accept && queue_op;
    assign pop      = state == S_LOAD && init_done;
    assign push_ent = {rd_op, cmd_data[16 +: ADDR_W], rd_op ? {DATA_W{1'b0}} : cmd_data[DATA_W-1:0]};
    assign ld_ent   = init_done ? fifo[rd_ptr] : {1'b0, ADDR_W'(ptr), init_cur[DATA_W-1:0]};

    assign ptr_last  = ptr == PTR_W'(INIT_DEPTH - 1);
    assign div_end   = div_cnt == DIV_W'(CLK_DIV - 1);
    assign bit_last  = bit_cnt == BIT_W'(FRAME_W - 1);
    assign shift_end = state == S_HI && div_end;
    assign init_step = !init_done && ((state == S_INIT && !init_cur[DATA_W]) || (state == S_GAP && gap_cnt));

    always_comb begin
        nxt = state;
        case (state)
            S_INIT:  if (init_cur[DATA_W]) nxt = S_LOAD;
                     else if (ptr_last)    nxt = S_IDLE;
            S_IDLE:  if (count != '0) nxt = S_LOAD;
            S_LOAD:  nxt = S_LO;
            S_LO:    if (div_end) nxt = S_HI;
            S_HI:    if (div_end) nxt = bit_last ? S_GAP : S_LO;
            S_GAP:   if (gap_cnt) nxt = (init_done || ptr_last) ? S_IDLE : S_INIT;
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= S_INIT;
            ptr               <= '0;
            init_done         <= 1'b0;
            div_cnt           <= '0;
            bit_cnt           <= '0;
            gap_cnt           <= 1'b0;
            tx                <= '0;
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            count             <= '0;
            cmd_ack           <= 1'b0;
            rffe_ad9866_sen_n <= 1'b1;
            rffe_ad9866_sclk  <= 1'b0;
        end else begin
            state             <= nxt;
            cmd_ack           <= accept;
            // pins are decoded from the next state so they are glitch-free registers
            rffe_ad9866_sen_n <= !(nxt == S_LO || nxt == S_HI);
            rffe_ad9866_sclk  <= nxt == S_HI;
            if (init_step) begin
                if (ptr_last) init_done <= 1'b1;
                else          ptr <= ptr + 1'b1;
            end
            div_cnt <= ((state == S_LO || state == S_HI) && !div_end) ? div_cnt + 1'b1 : '0;
            gap_cnt <= state == S_GAP && !gap_cnt;
            if (state == S_LOAD) begin
                tx      <= {ld_ent[ENT_W-1], 2'b00, ld_ent[ENT_W-2:0]};
                bit_cnt <= '0;
            end else if (shift_end) begin
                tx      <= {tx[FRAME_W-2:0], 1'b0};
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (FP_W+1)'(push) - (FP_W+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo[wr_ptr] <= push_ent;
    end

    // tx drains to zero after the last bit, so sdio idles low
    assign rffe_ad9866_sdio = tx[FRAME_W-1];

`ifdef AD9866_READBACK_EN
    logic              is_rd, samp;
    logic [DATA_W-1:0] rx, rx_next;
    logic              unused_cmd;

    assign samp       = state == S_HI && div_cnt == '0;
    assign rx_next    = {rx[DATA_W-2:0], rffe_ad9866_sdo};
    assign unused_cmd = ^cmd_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_rd    <= 1'b0;
            rx       <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= shift_end && bit_last && is_rd;
            if (state == S_LOAD) is_rd <= ld_ent[ENT_W-1];
            if (samp) rx <= rx_next;
            // with CLK_DIV=1 the final sample lands in this same cycle
            if (shift_end && bit_last && is_rd) rd_data <= samp ? rx_next : rx;
        end
    end
`else
    logic unused_in;
    assign unused_in = ^{cmd_data, rffe_ad9866_sdo};
    assign rd_data   = '0;
    assign rd_valid  = 1'b0;
`endif
endmodule

// File: tb/tb_ad9866_spi_master.sv
// Scoreboard bench for ad9866_spi_master: expected frames are queued at issue time and
// a pin-level monitor decodes each SPI frame and pops/compares.
module tb_ad9866_spi_master;
    localparam int CLK_DIV = 2;
    localparam int N_INIT  = 13;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic [5:0]  cmd_addr = '0;
    logic [31:0] cmd_data = '0;
    logic        cmd_rqst = 1'b0;
    logic        cmd_ack, rd_valid, init_done;
    logic [7:0]  rd_data;
    logic        sdio, sclk, sen_n;
    logic        sdo = 1'b0;

    always #5 clk = ~clk;

    ad9866_spi_master #(.CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .cmd_rqst(cmd_rqst), .cmd_ack(cmd_ack), .rd_data(rd_data), .rd_valid(rd_valid),
        .init_done(init_done), .rffe_ad9866_sdio(sdio), .rffe_ad9866_sdo(sdo),
        .rffe_ad9866_sclk(sclk), .rffe_ad9866_sen_n(sen_n)
    );

    int checks = 0, failures = 0;
    logic [15:0] exp_q[$];
    logic [7:0]  rd_q[$];
    int nframes = 0, rv_cnt = 0, nreads_exp = 0;
    bit done_seen = 0;

    int unsigned init_addr[N_INIT] = '{4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 18};
    logic [7:0]  init_dat[N_INIT]  = '{8'h36, 8'h00, 8'h1C, 8'h00, 8'h00, 8'h08, 8'h20,
                                      8'h80, 8'h40, 8'h0F, 8'h01, 8'h44, 8'h00};

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [15:0] wframe(input logic [4:0] a, input logic [7:0] d);
        return {3'b000, a, d};
    endfunction

    function automatic logic [15:0] rframe(input logic [4:0] a);
        return {3'b100, a, 8'h00};
    endfunction

    task automatic push_init();
        for (int i = 0; i < N_INIT; i++) exp_q.push_back(wframe(5'(init_addr[i]), init_dat[i]));
    endtask

    // pin monitor, sampled on the falling clk edge
    logic psen = 1'b1, psclk = 1'b0, pdone = 1'b0, in_frame = 1'b0, perr, serr, hold;
    int nb = 0, cyc = 0, hi_gap = 100;
    logic [15:0] bits, e;
    logic [7:0] p;
    always @(negedge clk) begin
        if (!rst_n) begin
            in_frame = 0; psen = 1; psclk = 0; pdone = 0; hi_gap = 100; nframes = 0; sdo = 0;
        end else begin
            if (in_frame) cyc++;
            if (psen && !sen_n) begin
                chk("sen_gap", 32'(hi_gap >= 2), 1);
                in_frame = 1; nb = 0; bits = '0; cyc = 0; perr = 0; serr = 0;
            end
            if (in_frame && sclk && !psclk) begin
                if (cyc != ((nb == 0) ? CLK_DIV : 2 * CLK_DIV)) perr = 1;
                cyc = 0; bits = {bits[14:0], sdio}; nb++; hold = sdio;
            end else if (in_frame && sclk && psclk && sdio !== hold) begin
                serr = 1;
            end
            if (in_frame && !psen && sen_n) begin
                in_frame = 0; hi_gap = 0; nframes++;
                chk("frame_bits", nb, 16);
                chk("sclk_timing", perr, 0);
                chk("sdio_stable", serr, 0);
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_frame: got %h expected none", bits);
                end else begin
                    e = exp_q.pop_front();
                    chk("frame", bits, e);
`ifdef AD9866_READBACK_EN
                    if (e[15]) begin
                        chk("rd_valid_gap", rd_valid, 1);
                        if (rd_q.size() > 0) begin
                            p = rd_q.pop_front();
                            chk("rd_data", rd_data, p);
                        end
                    end
`endif
                end
            end
            if (sen_n) hi_gap++;
            if (rd_valid) rv_cnt++;
            if (init_done && !pdone) begin
                done_seen = 1;
                chk("init_frames", nframes, N_INIT);
                chk("done_after_gap", in_frame, 0);
            end
            // device model: data bits of a read driven while sclk is low
            if (!sclk) begin
                if (in_frame && nb >= 8 && nb < 16 && rd_q.size() > 0) begin
                    p = rd_q[0];
                    sdo = p[15 - nb];
                end else sdo = 0;
            end
            psen = sen_n; psclk = sclk; pdone = init_done;
        end
    end

    task automatic send(input logic [5:0] a, input logic [31:0] d, output int w);
        cmd_addr = a; cmd_data = d; cmd_rqst = 1'b1; w = 0;
        do begin @(posedge clk); #1; w++; end while (!cmd_ack && w < 4000);
        chk("ack_timeout", 32'(cmd_ack), 1);
        cmd_rqst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || !sen_n) && t < 6000) begin @(posedge clk); #1; t++; end
        chk("drain_timeout", 32'(t < 6000), 1);
        repeat (80) @(posedge clk);
        #1;
    endtask

    task automatic queue_read(input logic [4:0] a, input logic [7:0] pat);
`ifdef AD9866_READBACK_EN
        exp_q.push_back(rframe(a));
        rd_q.push_back(pat);
        nreads_exp++;
`endif
    endtask

    initial begin
        int w, n0, t, kind;
        logic [4:0] a;
        logic [7:0] d, op;
        logic [5:0] ca;

        repeat (4) @(posedge clk);
        #1;
        chk("rst_sen_n", sen_n, 1);    chk("rst_sclk", sclk, 0);
        chk("rst_sdio", sdio, 0);      chk("rst_ack", cmd_ack, 0);
        chk("rst_rd_valid", rd_valid, 0); chk("rst_rd_data", rd_data, 0);
        chk("rst_init_done", init_done, 0);
        push_init();
        rst_n = 1'b1;

        // five writes during init; the fifth must wait for the first pop
        for (int i = 0; i < 5; i++) begin
            a = 5'($urandom); d = 8'($urandom);
            exp_q.push_back(wframe(a, d));
            send(6'h3b, {8'h06, 3'b000, a, 8'h00, d}, w);
            if (i < 4) chk("ack_prompt", w, 1);
            else begin
                chk("ack_held", 32'(w > 1), 1);
                chk("ack5_after_done", init_done, 1);
            end
        end
        drain();
        chk("done_seen", 32'(done_seen), 1);

        exp_q.push_back(16'h0A45);
        send(6'h3b, 32'h060A_0045, w);
        chk("ack_next", w, 1);
        drain();

        n0 = nframes;
        send(6'h10, 32'h060A_0045, w);
        chk("other_ack_next", w, 1);
        drain();
        chk("other_no_frame", nframes, n0);

        n0 = nframes;
        queue_read(5'h09, 8'hA5);
        send(6'h3b, 32'h0709_0000, w);
        chk("read_ack_next", w, 1);
        drain();
`ifdef AD9866_READBACK_EN
        chk("read_frame_count", nframes, n0 + 1);
`else
        chk("read_dropped", nframes, n0);
`endif

        for (int i = 0; i < 14; i++) begin
            kind = $urandom_range(0, 3);
            a = 5'($urandom); d = 8'($urandom);
            if (kind <= 1) begin
                exp_q.push_back(wframe(a, d));
                send(6'h3b, {8'h06, 3'b000, a, 8'h00, d}, w);
            end else if (kind == 2) begin
                ca = 6'($urandom); op = 8'($urandom);
                if ($urandom_range(0, 1) == 1) begin
                    if (ca == 6'h3b) ca = 6'h10;
                end else begin
                    ca = 6'h3b;
                    if (op == 8'h06 || op == 8'h07) op = 8'h00;
                end
                send(ca, {op, 3'b000, a, 8'h00, d}, w);
            end else begin
                queue_read(a, d);
                send(6'h3b, {8'h07, 3'b000, a, 8'h00, d}, w);
            end
        end
        drain();

        // reset in the middle of bit 7 with two writes still queued
        for (int i = 0; i < 3; i++) begin
            a = 5'($urandom); d = 8'($urandom);
            exp_q.push_back(wframe(a, d));
            send(6'h3b, {8'h06, 3'b000, a, 8'h00, d}, w);
        end
        t = 0;
        while (!(in_frame && nb == 8 && sclk) && t < 2000) begin @(posedge clk); #1; t++; end
        chk("bit7_timeout", 32'(t < 2000), 1);
        rst_n = 1'b0;
        exp_q.delete(); rd_q.delete();
        #1;
        chk("mid_rst_sen_n", sen_n, 1); chk("mid_rst_sclk", sclk, 0);
        chk("mid_rst_sdio", sdio, 0);   chk("mid_rst_done", init_done, 0);
        repeat (3) @(posedge clk);
        #1;
        done_seen = 0;
        push_init();
        rst_n = 1'b1;
        drain();
        chk("replay_done_seen", 32'(done_seen), 1);

        chk("rd_valid_count", rv_cnt, nreads_exp);
`ifndef AD9866_READBACK_EN
        chk("rd_data_tied", rd_data, 0);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ad9866_spi_master.md
# ad9866_spi_master

Parametrised SPI register controller for the AD9866 front end, successor to the fixed 16-bit write-only controller. It plays an init table after reset and queues host writes from the command slave bus into a small FIFO. It serialises each entry with a programmable SCLK divider and, when compiled in, performs 4-wire register readback to the command side. It sits between the command slave bus and the `rffe_ad9866_*` pins.

## Interface
- `ADDR_W`, 5: register address width.
- `DATA_W`, 8: register data width.
- `FRAME_W`, `3+ADDR_W+DATA_W`: frame length, laid out as R/W bit, 2 zero bits, address, data, MSB first.
- `CLK_DIV`, 2: SCLK half-period in `clk` cycles (≥1).
- `INIT_DEPTH`, 20: init table entries; the address of entry i is i.
- `INIT_FILE`, "ad9866_init.hex": hex file with `DATA_W+1` bits per entry; the MSB is the issue enable.
- `FIFO_DEPTH`, 4: command FIFO entries (power of 2).

Ports:
- `clk`  in  1: system clock.
- `rst_n`  in  1: asynchronous active-low reset.
- `cmd_addr`  in  6: command slave address.
- `cmd_data`  in  32: command slave data.
- `cmd_rqst`  in  1: command request, held until ack.
- `cmd_ack`  out  1: one-cycle acknowledge.
- `rd_data`  out  DATA_W: last readback value.
- `rd_valid`  out  1: one-cycle strobe when `rd_data` updates.
- `init_done`  out  1: high once the init table has completed.
- `rffe_ad9866_sdio`  out  1: serial data to the AD9866.
- `rffe_ad9866_sdo`  in  1: serial data from the AD9866.
- `rffe_ad9866_sclk`  out  1: SPI clock.
- `rffe_ad9866_sen_n`  out  1: chip enable, active low.

## Operation
Reset values: `sen_n`=1, `sclk`=0, `sdio`=0, `cmd_ack`=0, `rd_valid`=0, `rd_data`=0, `init_done`=0. FIFO is empty and the init pointer is 0.

Command slave:
- Only `cmd_addr`=6'h3b is decoded.
  - `cmd_data[31:24]`=8'h06: write. Address is `cmd_data[16+:ADDR_W]`, data is `cmd_data[DATA_W-1:0]`.
  - `cmd_data[31:24]`=8'h07: read. Address field as for write.
- Any other address, or any other opcode at 6'h3b, is acked with no effect.
- Accepted opcodes are pushed when the FIFO is not full, and `cmd_ack` is pulsed in the next cycle.
- If the FIFO is full, ack is withheld until space frees. The requester keeps `cmd_rqst` high.
- Requests arriving during init are queued normally.

SPI engine states:
- INIT: walk entries 0..INIT_DEPTH-1. Enabled entries go to LOAD; disabled entries take one cycle each. After the last entry, assert `init_done` (sticky) and go to IDLE.
- IDLE: if the FIFO is non-empty, pop to LOAD.
- LOAD (1 cycle): latch the frame, `sen_n`←0, `sdio`←MSB.
- SHIFT_LO: `sclk`=0 for CLK_DIV cycles, then go to SHIFT_HI.
- SHIFT_HI: `sclk`=1 for CLK_DIV cycles. At the first cycle of the high phase, sample `sdo` into the receive shift register. At the end of the high phase, shift `sdio` to the next bit. After bit FRAME_W-1 go to GAP, otherwise go to SHIFT_LO.
- GAP (2 cycles): `sen_n`=1, `sclk`=0. Then return to INIT (pointer+1) or IDLE.

## Timing
- Transaction length: 1 + 2·CLK_DIV·FRAME_W + 2 cycles. With defaults this is 67 cycles.
- `sdio` changes only while `sclk`=0. The first rising edge of SCLK is CLK_DIV cycles after `sen_n` falls.
- Read frames: `rd_data` takes the last DATA_W sampled bits. `rd_valid` pulses in the first GAP cycle.
- A push and a pop in the same cycle are both performed, and the count is unchanged. When the FIFO is full, a pop in a cycle allows the ack one cycle later.
- Asserting `rst_n` mid-frame immediately forces the reset values. The frame is abandoned, the FIFO is flushed, and init restarts from entry 0 after release.
- `cmd_ack` never pulses on two consecutive cycles for the same held request. After an ack, the requester must drop `cmd_rqst` for at least one cycle.

## Configuration
- `AD9866_READBACK_EN` defined: read opcode 8'h07 is queued. Its frame R/W bit is 1 and its data field is 0. `sdo` is sampled and `rd_data`/`rd_valid` are driven.
- Not defined: opcode 8'h07 is acked and dropped with no frame issued. `rd_data` is tied 0, `rd_valid` is tied 0, and `rffe_ad9866_sdo` is ignored.

## Test plan
- Reset with the default init file: exactly 13 frames are issued, with first frame bits 16'h0436 and last frame 16'h1200. `init_done` rises after the last GAP, and `sen_n` is high for ≥2 cycles between frames.
- Send write `cmd_data`=32'h060A_0045 after init: ack one cycle later. Frame 16'h0A45 appears MSB first, with each bit stable across the SCLK high phase. SCLK period is 4 clk.
- Send 5 back-to-back writes with FIFO_DEPTH=4 during init: 4 acks arrive promptly. The 5th ack is held until the first pop. All 5 frames are issued in order after `init_done`.
- With the readback macro defined, send read 32'h0709_0000 while a bench model drives `sdo`=8'hA5 on the data bits: frame 16'h8900 is issued, `rd_valid` pulses once, and `rd_data`=8'hA5. Without the macro, the read is acked and no frame is issued.
- Pull `rst_n` low in the middle of frame bit 7: `sen_n`=1 and `sclk`=0 within the same cycle, and the FIFO is empty. After release, init replays from entry 0.
- Send a request to `cmd_addr`=6'h10: acked in the next cycle, no frame issued, FIFO count unchanged.
